blk_ae97bf: RTL and testbench
=============================

// Module: logistic_regression_hls_deadlock_report_collector
// PURPOSE
//   Consumer end of the dataflow deadlock monitors: gathers the 'block' flags of all monitor instances,
//   filters transients by requiring PERSIST_CYCLES consecutive assertion, then emits one timestamped
//   deadlock report over a valid/ready handshake. Sticky 'deadlock' flag held until software/TB 'clear'.
//   Sits at top of the HLS IP beside the monitor instances; feeds the cosim TB or a debug status register.
// PARAMETERS
//   NUM_MON         4    number of monitor block inputs (1..32)
//   PERSIST_CYCLES  16   consecutive high cycles needed to confirm a monitor (2..255)
//   TS_W            32   width of free-running cycle timestamp
//   IDX_W           2    width of report_idx; must be >= clog2(NUM_MON), min 1
// PORTS
//   clock         in   1        single clock, all logic rising-edge
//   reset         in   1        synchronous, active-high
//   enable        in   1        1 = detection active; 0 = persistence counters held at 0
//   clear         in   1        1-cycle pulse: drop report/deadlock, return to scanning
//   mon_block     in   NUM_MON  block outputs of deadlock monitors, bit i = monitor i
//   report_valid  out  1        report payload valid
//   report_ready  in   1        consumer accepts report when valid & ready
//   report_idx    out  IDX_W    lowest-index confirmed monitor
//   report_mask   out  NUM_MON  all monitors confirmed in the capture cycle
//   report_ts     out  TS_W     timestamp value in the capture cycle
//   deadlock      out  1        sticky: set on report handshake, cleared by clear/reset
// BEHAVIOUR
//   Reset: state=SCAN; report_valid=0, report_idx=0, report_mask=0, report_ts=0, deadlock=0;
//     timestamp=0; all persistence counters=0.
//   Timestamp: increments every cycle after reset, wraps 2^TS_W-1 -> 0; unaffected by enable/clear.
//   Persistence counter i (8 bit): if !enable or clear or !mon_block[i] -> 0; else increments,
//     saturates at PERSIST_CYCLES. confirmed[i] = (cnt_i == PERSIST_CYCLES) & mon_block[i].
//     mon_block[i] high N consecutive enabled cycles -> confirmed on cycle N; any low cycle restarts.
//   FSM:
//     SCAN:   if any confirmed (and !clear): capture mask=confirmed, idx=lowest set bit, ts=timestamp;
//             -> REPORT. report_valid=1 from the following cycle (1-cycle latency).
//     REPORT: report_valid=1; idx/mask/ts stable while !report_ready. valid&ready -> HALT,
//             report_valid=0 and deadlock=1 next cycle. mon_block changes ignored.
//     HALT:   deadlock=1, no further reports; counters continue but are not sampled.
//   clear (any state, highest priority after reset): next cycle state=SCAN, report_valid=0,
//     deadlock=0, counters=0; payload regs keep last values. clear in REPORT aborts report (no handshake).
//   clear and report_ready same cycle in REPORT: clear wins; deadlock stays 0.
//   enable=0 only blocks new confirmation; a pending REPORT/HALT is unaffected.
//   Multiple monitors confirming same cycle: single report, mask has all bits, idx = lowest.
//   report_ready while !report_valid: ignored.
// CONFIGURATION
//   DEADLOCK_REPORT_COUNT_EN defined: adds output port report_count [15:0]; increments on each
//     valid&ready handshake, saturates at 16'hFFFF, reset to 0 only by reset (not by clear).
//   Undefined: port and counter absent; all other behaviour identical.
// TESTING
//   T1 reset, enable=1, mon_block=0 for 100 cycles -> report_valid=0, deadlock=0 throughout.
//   T2 PERSIST_CYCLES=16, mon_block[2] high 15 cycles then low 1, repeat 5x -> no report.
//   T3 mon_block=4'b1010 from ts=40 held, ready=1 -> valid at ts=56, idx=1, mask=4'b1010,
//      report_ts=55, deadlock=1 at ts=57.
//   T4 ready=0 for 10 cycles while valid, mon_block toggled -> payload constant; ready=1 -> HALT,
//      no second report while mon_block stays high.
//   T5 clear in HALT then mon_block[0] high 16 cycles -> deadlock=0 after clear, second report idx=0;
//      with DEADLOCK_REPORT_COUNT_EN report_count=2, still 2 after a further clear.
//   T6 clear and ready same cycle in REPORT -> deadlock stays 0, valid drops; reset mid-REPORT ->
//      all outputs at reset values next cycle.

Source files
------------

// File: rtl/blk_ae97bf.sv
// Deadlock report collector: watches the block flags of the dataflow deadlock
// monitors and requires each flag to persist before it is trusted. It then
// emits a single timestamped report over valid/ready and latches a sticky
// deadlock flag until clear.
// Optional feature: define DEADLOCK_REPORT_COUNT_EN to add a saturating
// report_count output that counts completed report handshakes.
module blk_ae97bf #(
  parameter int NUM_MON        = 4,
  parameter int PERSIST_CYCLES = 16,
  parameter int TS_W           = 32,
  parameter int IDX_W          = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [NUM_MON-1:0] mon_block,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [IDX_W-1:0]   report_idx,
  output logic [NUM_MON-1:0] report_mask,
  output logic [TS_W-1:0]    report_ts,
  output logic               deadlock
`ifdef DEADLOCK_REPORT_COUNT_EN
  ,
  output logic [15:0]        report_count
`endif
);

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    REPORT = 2'd1,
    HALT   = 2'd2
  } state_t;

  localparam logic [7:0] PERSIST_MAX = 8'(PERSIST_CYCLES);

  state_t             state_q;
  state_t             state_d;
  logic               capture;
  logic [TS_W-1:0]    timestamp;
  logic [7:0]         cnt_q [NUM_MON];
  logic [7:0]         cnt_d [NUM_MON];
  logic [NUM_MON-1:0] confirmed;
  logic [IDX_W-1:0]   low_idx;

  // Free-running cycle timestamp; only reset stops it, wrap is natural overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      timestamp <= '0;
    end else begin
      timestamp <= timestamp + 1'b1;
    end
  end

  // Next persistence count per monitor; a monitor is confirmed in the cycle
  // its count reaches the threshold, so N high cycles confirm on cycle N
  always_comb begin
    confirmed = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      cnt_d[i] = 8'd0;
      if (enable && !clear && mon_block[i]) begin
        cnt_d[i] = (cnt_q[i] == PERSIST_MAX) ? PERSIST_MAX : cnt_q[i] + 8'd1;
      end
      confirmed[i] = (cnt_d[i] == PERSIST_MAX) && mon_block[i];
    end
  end

  // Persistence counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_MON; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NUM_MON; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Lowest-index confirmed monitor; scanning downward lets the lowest set bit win
  always_comb begin
    low_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (confirmed[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SCAN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; clear overrides everything, including a same-cycle handshake
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (clear) begin
      state_d = SCAN;
    end else begin
      case (state_q)
        SCAN: begin
          if (|confirmed) begin
            capture = 1'b1;
            state_d = REPORT;
          end
        end
        REPORT: begin
          if (report_ready) begin
            state_d = HALT;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = SCAN;
        end
      endcase
    end
  end

  // Report payload is captured once on entry to REPORT and then held, even across clear
  always_ff @(posedge clock) begin
    if (reset) begin
      report_idx  <= '0;
      report_mask <= '0;
      report_ts   <= '0;
    end else if (capture) begin
      report_idx  <= low_idx;
      report_mask <= confirmed;
      report_ts   <= timestamp;
    end
  end

  assign report_valid = (state_q == REPORT);
  assign deadlock     = (state_q == HALT);

`ifdef DEADLOCK_REPORT_COUNT_EN
  logic handshake;
  assign handshake = report_valid && report_ready && !clear;

  // Saturating count of completed report handshakes; survives clear
  always_ff @(posedge clock) begin
    if (reset) begin
      report_count <= 16'd0;
    end else if (handshake && (report_count != 16'hFFFF)) begin
      report_count <= report_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_blk_ae97bf.sv
// Directed testbench for blk_ae97bf with default parameters
// (NUM_MON=4, PERSIST_CYCLES=16, TS_W=32, IDX_W=2).
module tb_blk_ae97bf;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [3:0]  mon_block;
  logic        report_valid;
  logic        report_ready;
  logic [1:0]  report_idx;
  logic [3:0]  report_mask;
  logic [31:0] report_ts;
  logic        deadlock;
`ifdef DEADLOCK_REPORT_COUNT_EN
  logic [15:0] report_count;
`endif

  int          errors;
  int          checks;
  logic [31:0] ts_model;

  blk_ae97bf dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .mon_block    (mon_block),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .report_idx   (report_idx),
    .report_mask  (report_mask),
    .report_ts    (report_ts),
    .deadlock     (deadlock)
`ifdef DEADLOCK_REPORT_COUNT_EN
    ,
    .report_count (report_count)
`endif
  );

  // 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one cycle; inputs set before the call are sampled at the rising edge,
  // and outputs are observed at the following falling edge
  task automatic tick();
    @(negedge clock);
    if (reset) ts_model = 32'd0;
    else       ts_model = ts_model + 32'd1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    clear        = 1'b0;
    enable       = 1'b1;
    mon_block    = 4'b0000;
    report_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (report_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", report_valid);
    end
    checks++;
    if (deadlock !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_deadlock: got %0b expected 0", deadlock);
    end
    checks++;
    if (report_idx !== 2'd0) begin
      errors++; $display("[TB] FAIL reset_idx: got %0d expected 0", report_idx);
    end
    checks++;
    if (report_mask !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_mask: got %b expected 0000", report_mask);
    end
    checks++;
    if (report_ts !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_ts: got %0d expected 0", report_ts);
    end
`ifdef DEADLOCK_REPORT_COUNT_EN
    checks++;
    if (report_count !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_count: got %0d expected 0", report_count);
    end
`endif
  endtask

  // No monitor asserted for 100 cycles: nothing is reported
  task automatic test_idle();
    enable    = 1'b1;
    mon_block = 4'b0000;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (report_valid !== 1'b0 || deadlock !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_cycle%0d: got valid=%0b deadlock=%0b expected 0 0", i, report_valid, deadlock);
      end
    end
  endtask

  // 15 high cycles followed by a low cycle never confirms
  task automatic test_transient();
    for (int r = 0; r < 5; r++) begin
      mon_block = 4'b0100;
      for (int i = 0; i < 15; i++) begin
        tick();
        checks++;
        if (report_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL transient_r%0d_c%0d: got valid=%0b expected 0", r, i, report_valid);
        end
      end
      mon_block = 4'b0000;
      tick();
      checks++;
      if (report_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL transient_r%0d_low: got valid=%0b expected 0", r, report_valid);
      end
    end
  endtask

  // Enable low holds counters at zero; after enabling, 16 cycles are needed
  task automatic test_enable();
    enable    = 1'b0;
    mon_block = 4'b1000;
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (report_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL enable_off_valid: got %0b expected 0", report_valid);
    end
    enable = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (report_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL enable_15_valid: got %0b expected 0", report_valid);
    end
    tick();
    checks++;
    if (report_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL enable_16_valid: got %0b expected 1", report_valid);
    end
    checks++;
    if (report_idx !== 2'd3 || report_mask !== 4'b1000) begin
      errors++; $display("[TB] FAIL enable_payload: got idx=%0d mask=%b expected 3 1000", report_idx, report_mask);
    end
  endtask

  // Two monitors confirming together from ts=40: report at ts=56, deadlock at ts=57
  task automatic test_multi_confirm();
    do_reset();
    for (int i = 0; i < 40; i++) tick();
    mon_block    = 4'b1010;
    report_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (report_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL multi_ts55_valid: got %0b expected 0", report_valid);
    end
    tick();
    checks++;
    if (report_valid !== 1'b1 || deadlock !== 1'b0) begin
      errors++; $display("[TB] FAIL multi_ts56_flags: got valid=%0b deadlock=%0b expected 1 0", report_valid, deadlock);
    end
    checks++;
    if (report_idx !== 2'd1) begin
      errors++; $display("[TB] FAIL multi_idx: got %0d expected 1", report_idx);
    end
    checks++;
    if (report_mask !== 4'b1010) begin
      errors++; $display("[TB] FAIL multi_mask: got %b expected 1010", report_mask);
    end
    checks++;
    if (report_ts !== 32'd55) begin
      errors++; $display("[TB] FAIL multi_ts: got %0d expected 55", report_ts);
    end
    tick();
    checks++;
    if (report_valid !== 1'b0 || deadlock !== 1'b1) begin
      errors++; $display("[TB] FAIL multi_ts57_flags: got valid=%0b deadlock=%0b expected 0 1", report_valid, deadlock);
    end
  endtask

  // Backpressure holds the payload while mon_block toggles; then HALT sticks
  task automatic test_backpressure();
    do_reset();
    mon_block = 4'b0100;
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (report_valid !== 1'b1 || report_idx !== 2'd2 || report_mask !== 4'b0100 || report_ts !== 32'd15) begin
      errors++;
      $display("[TB] FAIL bp_first: got valid=%0b idx=%0d mask=%b ts=%0d expected 1 2 0100 15", report_valid, report_idx, report_mask, report_ts);
    end
    for (int i = 0; i < 10; i++) begin
      mon_block = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      tick();
      checks++;
      if (report_valid !== 1'b1 || report_idx !== 2'd2 || report_mask !== 4'b0100 || report_ts !== 32'd15) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got valid=%0b idx=%0d mask=%b ts=%0d expected 1 2 0100 15", i, report_valid, report_idx, report_mask, report_ts);
      end
    end
    mon_block    = 4'b1111;
    report_ready = 1'b1;
    tick();
    checks++;
    if (report_valid !== 1'b0 || deadlock !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_accept: got valid=%0b deadlock=%0b expected 0 1", report_valid, deadlock);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (report_valid !== 1'b0 || deadlock !== 1'b1 || report_mask !== 4'b0100) begin
        errors++;
        $display("[TB] FAIL bp_halt%0d: got valid=%0b deadlock=%0b mask=%b expected 0 1 0100", i, report_valid, deadlock, report_mask);
      end
    end
  endtask

  // Clear in HALT restarts scanning; a second report follows
  task automatic test_clear_rearm();
    logic [31:0] cap_ts;
    clear        = 1'b1;
    report_ready = 1'b0;
    mon_block    = 4'b0001;
    tick();
    clear = 1'b0;
    checks++;
    if (deadlock !== 1'b0 || report_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_halt: got deadlock=%0b valid=%0b expected 0 0", deadlock, report_valid);
    end
    checks++;
    if (report_mask !== 4'b0100) begin
      errors++; $display("[TB] FAIL clr_keep_mask: got %b expected 0100", report_mask);
    end
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (report_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_15_valid: got %0b expected 0", report_valid);
    end
    cap_ts = ts_model;
    tick();
    checks++;
    if (report_valid !== 1'b1 || report_idx !== 2'd0 || report_mask !== 4'b0001 || report_ts !== cap_ts) begin
      errors++;
      $display("[TB] FAIL clr_second: got valid=%0b idx=%0d mask=%b ts=%0d expected 1 0 0001 %0d", report_valid, report_idx, report_mask, report_ts, cap_ts);
    end
    report_ready = 1'b1;
    tick();
    checks++;
    if (deadlock !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_second_dl: got %0b expected 1", deadlock);
    end
`ifdef DEADLOCK_REPORT_COUNT_EN
    checks++;
    if (report_count !== 16'd2) begin
      errors++; $display("[TB] FAIL count_two: got %0d expected 2", report_count);
    end
`endif
    clear        = 1'b1;
    report_ready = 1'b0;
    mon_block    = 4'b0000;
    tick();
    clear = 1'b0;
    checks++;
    if (deadlock !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_again_dl: got %0b expected 0", deadlock);
    end
`ifdef DEADLOCK_REPORT_COUNT_EN
    checks++;
    if (report_count !== 16'd2) begin
      errors++; $display("[TB] FAIL count_after_clear: got %0d expected 2", report_count);
    end
`endif
  endtask

  // Clear beats a same-cycle handshake; reset in REPORT restores reset values
  task automatic test_abort();
    mon_block    = 4'b0010;
    report_ready = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (report_valid !== 1'b1 || report_idx !== 2'd1) begin
      errors++; $display("[TB] FAIL abort_pre: got valid=%0b idx=%0d expected 1 1", report_valid, report_idx);
    end
    clear        = 1'b1;
    report_ready = 1'b1;
    mon_block    = 4'b0000;
    tick();
    clear = 1'b0;
    checks++;
    if (report_valid !== 1'b0 || deadlock !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_clear: got valid=%0b deadlock=%0b expected 0 0", report_valid, deadlock);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (deadlock !== 1'b0 || report_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_after: got valid=%0b deadlock=%0b expected 0 0", report_valid, deadlock);
    end
`ifdef DEADLOCK_REPORT_COUNT_EN
    checks++;
    if (report_count !== 16'd2) begin
      errors++; $display("[TB] FAIL abort_count: got %0d expected 2", report_count);
    end
`endif
    mon_block    = 4'b0010;
    report_ready = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (report_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_pre_valid: got %0b expected 1", report_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (report_valid !== 1'b0 || deadlock !== 1'b0 || report_idx !== 2'd0 || report_mask !== 4'b0000 || report_ts !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_report: got valid=%0b deadlock=%0b idx=%0d mask=%b ts=%0d expected all 0", report_valid, deadlock, report_idx, report_mask, report_ts);
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    ts_model     = 32'd0;
    reset        = 1'b1;
    enable       = 1'b0;
    clear        = 1'b0;
    mon_block    = 4'b0000;
    report_ready = 1'b0;
    test_reset();
    test_idle();
    test_transient();
    test_enable();
    test_multi_confirm();
    test_backpressure();
    test_clear_rearm();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
